// File: rtl/knn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : knn_pkg
// Description : Shared types for the KNN top-K sorter: sorter state encoding
//               and the slot record layout {occ, id, value}.
// Revision    : 1.0 - initial release
// ============================================================================
package knn_pkg;

    localparam int c_VAL_WIDTH = 32;
    localparam int c_ID_WIDTH  = 32;

    // ACCEPT collects samples, DRAIN streams the ranked result out
    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    // One ranked entry at the default widths
    typedef struct packed {
        logic                   occ;
        logic [c_ID_WIDTH-1:0]  id;
        logic [c_VAL_WIDTH-1:0] value;
    } slot_t;

endpackage
`default_nettype wire

// File: rtl/knn_topk_cell.sv
`default_nettype none
// ============================================================================
// Module      : knn_topk_cell
// Description : One slot of the top-K insertion chain. Holds {occ, id, value},
//               reports whether a new sample outranks it, and on an insert
//               either holds, takes the neighbour's entry, or loads the sample.
// Revision    : 1.0 - initial release
// ============================================================================
module knn_topk_cell
    import knn_pkg::*;
#(
    parameter int VAL_WIDTH    = 32,
    parameter int ID_WIDTH     = 32,
    parameter int TIE_KEEP_OLD = 1
) (
    input  logic                 clk,
    input  logic                 flush,
    input  logic                 insert,
    input  logic [VAL_WIDTH-1:0] inValue,
    input  logic [ID_WIDTH-1:0]  newId,
    input  logic                 prevBeat,
    input  logic                 prevOcc,
    input  logic [ID_WIDTH-1:0]  prevId,
    input  logic [VAL_WIDTH-1:0] prevValue,
    output logic                 beat,
    output logic                 occ,
    output logic [ID_WIDTH-1:0]  id,
    output logic [VAL_WIDTH-1:0] value
);

    logic                 r_occ;
    logic [ID_WIDTH-1:0]  r_id;
    logic [VAL_WIDTH-1:0] r_value;
    logic                 w_beat;

    // A free slot is always beaten; otherwise compare under the tie policy
    always_comb begin
        w_beat = 1'b0;
        if (!r_occ) begin
            w_beat = 1'b1;
        end else if (TIE_KEEP_OLD != 0) begin
            w_beat = (inValue < r_value);
        end else begin
            w_beat = (inValue <= r_value);
        end
    end

    // Slot update: shift in from the neighbour when the insert point is below,
    // load the new sample when this is the insert point, otherwise hold
    always_ff @(posedge clk) begin
        if (flush) begin
            r_occ   <= 1'b0;
            r_id    <= '0;
            r_value <= '0;
        end else if (insert) begin
            if (prevBeat) begin
                r_occ   <= prevOcc;
                r_id    <= prevId;
                r_value <= prevValue;
            end else if (w_beat) begin
                r_occ   <= 1'b1;
                r_id    <= newId;
                r_value <= inValue;
            end
        end
    end

    assign beat  = w_beat;
    assign occ   = r_occ;
    assign id    = r_id;
    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/knn_topk_sorter.sv
`default_nettype none
// ============================================================================
// Module      : knn_topk_sorter
// Description : Streaming top-K insertion sorter. Keeps the K smallest
//               distances of a query in ascending order, tagged with
//               generated sample IDs, then drains them over valid/ready and
//               re-arms itself after the final entry.
// Revision    : 1.0 - initial release
// ============================================================================
module knn_topk_sorter
    import knn_pkg::*;
#(
    parameter int K            = 8,
    parameter int VAL_WIDTH    = 32,
    parameter int ID_WIDTH     = 32,
    parameter int ID_STRIDE    = 2,
    parameter int TIE_KEEP_OLD = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [ID_WIDTH-1:0]      id_base,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [VAL_WIDTH-1:0]     in_value,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ID_WIDTH-1:0]      out_id,
    output logic [VAL_WIDTH-1:0]     out_value,
    output logic                     out_last,
    output logic [$clog2(K+1)-1:0]   out_count
);

    localparam int                  c_CNT_W  = $clog2(K + 1);
    localparam logic [c_CNT_W-1:0]  c_ONE    = c_CNT_W'(1);
    localparam logic [ID_WIDTH-1:0] c_STRIDE = ID_WIDTH'(ID_STRIDE);

    state_t               r_state;
    logic [ID_WIDTH-1:0]  r_idCtr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_rdPtr;
    logic                 r_outValid;
    logic                 r_outLast;

    logic                 w_accept;
    logic                 w_drainHs;
    logic                 w_rearm;
    logic                 w_flush;
    logic [c_CNT_W-1:0]   w_countNext;

    logic [K-1:0]         w_beat;
    logic [K-1:0]         w_occ;
    logic [ID_WIDTH-1:0]  w_id    [K];
    logic [VAL_WIDTH-1:0] w_value [K];
    logic                 w_unusedTailBeat;

    logic [ID_WIDTH-1:0]  w_selId;
    logic [VAL_WIDTH-1:0] w_selValue;

    assign w_accept  = in_valid && (r_state == ACCEPT);
    assign w_drainHs = r_outValid && out_ready;
    assign w_rearm   = w_drainHs && r_outLast;
    assign w_flush   = reset || clear || w_rearm;

    // The count tracks occupancy: it grows only while the tail slot is free
    assign w_countNext = w_occ[K-1] ? r_count : (r_count + c_ONE);

    // Nothing sits behind the tail slot, so its beat flag has no consumer
    assign w_unusedTailBeat = w_beat[K-1];

    // Insertion chain: each slot sees its lower neighbour's beat flag and entry
    for (genvar j = 0; j < K; j++) begin : g_cell
        logic                 w_prevBeat;
        logic                 w_prevOcc;
        logic [ID_WIDTH-1:0]  w_prevId;
        logic [VAL_WIDTH-1:0] w_prevValue;

        if (j == 0) begin : g_head
            assign w_prevBeat  = 1'b0;
            assign w_prevOcc   = 1'b0;
            assign w_prevId    = '0;
            assign w_prevValue = '0;
        end else begin : g_body
            assign w_prevBeat  = w_beat[j-1];
            assign w_prevOcc   = w_occ[j-1];
            assign w_prevId    = w_id[j-1];
            assign w_prevValue = w_value[j-1];
        end

        knn_topk_cell #(
            .VAL_WIDTH    (VAL_WIDTH),
            .ID_WIDTH     (ID_WIDTH),
            .TIE_KEEP_OLD (TIE_KEEP_OLD)
        ) u_cell (
            .clk       (clk),
            .flush     (w_flush),
            .insert    (w_accept),
            .inValue   (in_value),
            .newId     (r_idCtr),
            .prevBeat  (w_prevBeat),
            .prevOcc   (w_prevOcc),
            .prevId    (w_prevId),
            .prevValue (w_prevValue),
            .beat      (w_beat[j]),
            .occ       (w_occ[j]),
            .id        (w_id[j]),
            .value     (w_value[j])
        );
    end

    // Control FSM: ID generation, occupancy count, read pointer and the
    // registered valid/last flags of the drain stream
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state    <= ACCEPT;
            r_idCtr    <= id_base;
            r_count    <= '0;
            r_rdPtr    <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end else begin
            case (r_state)
                ACCEPT: begin
                    if (in_valid) begin
                        r_idCtr <= r_idCtr + c_STRIDE;
                        r_count <= w_countNext;
                        if (in_last) begin
                            r_state    <= DRAIN;
                            r_rdPtr    <= '0;
                            r_outValid <= 1'b1;
                            r_outLast  <= (w_countNext == c_ONE);
                        end
                    end
                end
                DRAIN: begin
                    if (w_drainHs) begin
                        if (r_outLast) begin
                            r_state    <= ACCEPT;
                            r_idCtr    <= id_base;
                            r_count    <= '0;
                            r_rdPtr    <= '0;
                            r_outValid <= 1'b0;
                            r_outLast  <= 1'b0;
                        end else begin
                            r_rdPtr    <= r_rdPtr + c_ONE;
                            r_outValid <= 1'b1;
                            r_outLast  <= ((r_rdPtr + c_ONE) == (r_count - c_ONE));
                        end
                    end
                end
                default: begin
                    r_state <= ACCEPT;
                end
            endcase
        end
    end

    // Drain mux: pick the slot addressed by the read pointer
    always_comb begin
        w_selId    = '0;
        w_selValue = '0;
        for (int j = 0; j < K; j++) begin
            if (r_rdPtr == c_CNT_W'(j)) begin
                w_selId    = w_id[j];
                w_selValue = w_value[j];
            end
        end
    end

    assign in_ready  = (r_state == ACCEPT);
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign out_count = r_count;
    assign out_id    = r_outValid ? w_selId    : '0;
    assign out_value = r_outValid ? w_selValue : '0;

endmodule
`default_nettype wire

// File: tb/tb_knn_topk_sorter.sv
`default_nettype none
// ============================================================================
// Module      : tb_knn_topk_sorter
// Description : Self-checking bench for knn_topk_sorter. Two K=4 instances,
//               one per tie policy, see identical stimulus: directed vectors,
//               hand-written abort/restart sequences and random queries
//               checked against a sort-and-truncate reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_topk_sorter;
    import knn_pkg::*;

    localparam int c_K = 4;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    logic [31:0] id_base;
    logic in_valid;
    logic [31:0] in_value;
    logic in_last;
    logic out_ready;

    logic [1:0]       inReady;
    logic [1:0]       outValid;
    logic [1:0]       outLast;
    logic [1:0][31:0] outId;
    logic [1:0][31:0] outValue;
    logic [1:0][2:0]  outCount;

    int nChecks = 0;
    int nFail   = 0;

    // Query under test and the expected ranked result per instance
    logic [31:0] qVals [16];
    int          qN;
    logic [31:0] exId  [2][16];
    logic [31:0] exVal [2][16];
    int          exN;

    typedef struct {
        int               n;
        logic [31:0]      base;
        logic [5:0][31:0] vals;
        int               expN;
        logic [3:0][31:0] expId0;
        logic [3:0][31:0] expId1;
        logic [3:0][31:0] expVal;
        int               mode;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    knn_topk_sorter #(
        .K(c_K), .VAL_WIDTH(32), .ID_WIDTH(32), .ID_STRIDE(2), .TIE_KEEP_OLD(1)
    ) u_dutOld (
        .clk(clk), .reset(reset), .clear(clear), .id_base(id_base),
        .in_valid(in_valid), .in_ready(inReady[0]), .in_value(in_value), .in_last(in_last),
        .out_valid(outValid[0]), .out_ready(out_ready), .out_id(outId[0]),
        .out_value(outValue[0]), .out_last(outLast[0]), .out_count(outCount[0])
    );

    knn_topk_sorter #(
        .K(c_K), .VAL_WIDTH(32), .ID_WIDTH(32), .ID_STRIDE(2), .TIE_KEEP_OLD(0)
    ) u_dutNew (
        .clk(clk), .reset(reset), .clear(clear), .id_base(id_base),
        .in_valid(in_valid), .in_ready(inReady[1]), .in_value(in_value), .in_last(in_last),
        .out_valid(outValid[1]), .out_ready(out_ready), .out_id(outId[1]),
        .out_value(outValue[1]), .out_last(outLast[1]), .out_count(outCount[1])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: rank all samples by value (ties by arrival order per policy),
    // keep the first K
    task automatic modelQuery(input logic [31:0] base);
        bit used [16];
        int best;
        exN = (qN < c_K) ? qN : c_K;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) used[i] = 1'b0;
            for (int r = 0; r < exN; r++) begin
                best = -1;
                for (int i = 0; i < qN; i++) begin
                    if (!used[i]) begin
                        if (best < 0 || qVals[i] < qVals[best] ||
                            (qVals[i] == qVals[best] && d == 1)) begin
                            best = i;
                        end
                    end
                end
                used[best]   = 1'b1;
                exId[d][r]  = base + 32'(2 * best);
                exVal[d][r] = qVals[best];
            end
        end
    endtask

    task automatic loadBase(input logic [31:0] base);
        id_base = base;
        clear   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear   = 1'b0;
    endtask

    // Feed qVals[0..qN-1] starting at a falling edge; optional idle gaps
    task automatic sendSamples(input bit withLast, input bit gaps);
        for (int i = 0; i < qN; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            in_valid = 1'b1;
            in_value = qVals[i];
            in_last  = withLast && (i == qN - 1);
            for (int d = 0; d < 2; d++)
                check($sformatf("in_ready s%0d dut%0d", i, d), 64'(inReady[d]), 64'd1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Drain and compare every presented cycle; mode 0 ready, 1 stall 3 cycles
    // on the second entry, 2 random ready
    task automatic drainCheck(input int mode);
        int  k = 0;
        int  stall = 0;
        bit  done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            case (mode)
                1:       if (k == 1 && stall < 3) begin out_ready = 1'b0; stall++; end
                         else out_ready = 1'b1;
                2:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
            for (int d = 0; d < 2; d++) begin
                check($sformatf("out_valid e%0d dut%0d", k, d), 64'(outValid[d]), 64'd1);
                check($sformatf("out_id e%0d dut%0d", k, d), 64'(outId[d]), 64'(exId[d][k]));
                check($sformatf("out_value e%0d dut%0d", k, d), 64'(outValue[d]), 64'(exVal[d][k]));
                check($sformatf("out_last e%0d dut%0d", k, d), 64'(outLast[d]), 64'(k == exN - 1));
                check($sformatf("out_count e%0d dut%0d", k, d), 64'(outCount[d]), 64'(exN));
            end
            if (out_ready) k++;
            if (k >= exN) done = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (!done) begin
            nChecks++;
            nFail++;
            $display("FAIL drain timeout: got %0d entries, expected %0d", k, exN);
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rearm in_ready dut%0d", d), 64'(inReady[d]), 64'd1);
            check($sformatf("rearm out_valid dut%0d", d), 64'(outValid[d]), 64'd0);
            check($sformatf("rearm out_count dut%0d", d), 64'(outCount[d]), 64'd0);
        end
    endtask

    task automatic setQuery(input int n, input logic [31:0] v0, input logic [31:0] v1,
                            input logic [31:0] v2);
        qN = n;
        qVals[0] = v0;
        qVals[1] = v1;
        qVals[2] = v2;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vectors: {n, base, values, expected count, ids per policy, values, ready mode}
        tbl[0] = '{5, 32'd0, {32'd0, 32'd40, 32'd20, 32'd30, 32'd10, 32'd50}, 4,
                   {32'd8, 32'd4, 32'd6, 32'd2}, {32'd8, 32'd4, 32'd6, 32'd2},
                   {32'd40, 32'd30, 32'd20, 32'd10}, 1};
        tbl[1] = '{2, 32'd5, {32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd7}, 2,
                   {32'd0, 32'd0, 32'd5, 32'd7}, {32'd0, 32'd0, 32'd5, 32'd7},
                   {32'd0, 32'd0, 32'd7, 32'd3}, 0};
        tbl[2] = '{3, 32'd0, {32'd0, 32'd0, 32'd0, 32'd9, 32'd9, 32'd9}, 3,
                   {32'd0, 32'd4, 32'd2, 32'd0}, {32'd0, 32'd0, 32'd2, 32'd4},
                   {32'd0, 32'd9, 32'd9, 32'd9}, 0};
        tbl[3] = '{1, 32'd0, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, 1,
                   {32'd0, 32'd0, 32'd0, 32'd0}, {32'd0, 32'd0, 32'd0, 32'd0},
                   {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, 0};
        tbl[4] = '{6, 32'd10, {32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 4,
                   {32'd14, 32'd12, 32'd10, 32'd20}, {32'd14, 32'd12, 32'd10, 32'd20},
                   {32'd3, 32'd2, 32'd1, 32'd0}, 2};

        reset     = 1'b1;
        clear     = 1'b0;
        id_base   = 32'd0;
        in_valid  = 1'b0;
        in_value  = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset in_ready dut%0d", d), 64'(inReady[d]), 64'd1);
            check($sformatf("reset out_valid dut%0d", d), 64'(outValid[d]), 64'd0);
            check($sformatf("reset out_id dut%0d", d), 64'(outId[d]), 64'd0);
            check($sformatf("reset out_value dut%0d", d), 64'(outValue[d]), 64'd0);
            check($sformatf("reset out_last dut%0d", d), 64'(outLast[d]), 64'd0);
            check($sformatf("reset out_count dut%0d", d), 64'(outCount[d]), 64'd0);
        end

        for (int t = 0; t < 5; t++) begin
            loadBase(tbl[t].base);
            qN = tbl[t].n;
            for (int i = 0; i < qN; i++) qVals[i] = tbl[t].vals[i];
            exN = tbl[t].expN;
            for (int i = 0; i < exN; i++) begin
                exId[0][i]  = tbl[t].expId0[i];
                exId[1][i]  = tbl[t].expId1[i];
                exVal[0][i] = tbl[t].expVal[i];
                exVal[1][i] = tbl[t].expVal[i];
            end
            sendSamples(1'b1, 1'b0);
            drainCheck(tbl[t].mode);
        end

        // Clear after two accepts, then the next sample gets id_base
        loadBase(32'h40);
        setQuery(2, 32'd5, 32'd6, 32'd0);
        sendSamples(1'b0, 1'b0);
        for (int d = 0; d < 2; d++)
            check($sformatf("pre-clear out_count dut%0d", d), 64'(outCount[d]), 64'd2);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("clear in_ready dut%0d", d), 64'(inReady[d]), 64'd1);
            check($sformatf("clear out_count dut%0d", d), 64'(outCount[d]), 64'd0);
        end
        setQuery(1, 32'd77, 32'd0, 32'd0);
        modelQuery(32'h40);
        sendSamples(1'b1, 1'b0);
        drainCheck(0);

        // Reset part way through a drain
        loadBase(32'd0);
        setQuery(3, 32'd12, 32'd11, 32'd13);
        sendSamples(1'b1, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("mid-drain reset out_valid dut%0d", d), 64'(outValid[d]), 64'd0);
            check($sformatf("mid-drain reset out_last dut%0d", d), 64'(outLast[d]), 64'd0);
            check($sformatf("mid-drain reset in_ready dut%0d", d), 64'(inReady[d]), 64'd1);
            check($sformatf("mid-drain reset out_count dut%0d", d), 64'(outCount[d]), 64'd0);
        end
        setQuery(1, 32'd33, 32'd0, 32'd0);
        modelQuery(32'd0);
        sendSamples(1'b1, 1'b0);
        drainCheck(0);

        // Back-to-back queries: the second restarts at id_base via re-arm
        loadBase(32'h200);
        setQuery(2, 32'd3, 32'd1, 32'd0);
        modelQuery(32'h200);
        sendSamples(1'b1, 1'b0);
        drainCheck(0);
        setQuery(3, 32'd8, 32'd6, 32'd7);
        exN = 3;
        exId[0][0] = 32'h202; exVal[0][0] = 32'd6;
        exId[0][1] = 32'h204; exVal[0][1] = 32'd7;
        exId[0][2] = 32'h200; exVal[0][2] = 32'd8;
        for (int i = 0; i < 3; i++) begin
            exId[1][i]  = exId[0][i];
            exVal[1][i] = exVal[0][i];
        end
        sendSamples(1'b1, 1'b0);
        drainCheck(0);

        // Random queries against the reference model
        for (int r = 0; r < 16; r++) begin
            logic [31:0] base;
            base = $urandom;
            qN = $urandom_range(1, 10);
            for (int i = 0; i < qN; i++) begin
                qVals[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 15));
            end
            loadBase(base);
            modelQuery(base);
            sendSamples(1'b1, 1'b1);
            drainCheck(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/knn_topk_sorter.md
Name: knn_topk_sorter

Overview:
Streaming top-K insertion sorter for the KNN accelerator. It keeps the K smallest distance values seen in one query, each tagged with a generated sample ID, in ascending order. It then drains them over a valid/ready stream. It succeeds the single-phase sorter with the following additions:
- input and output handshakes
- explicit per-slot occupancy, so an all-ones distance is a legal value
- configurable ID base and stride
- a tie policy
- automatic re-arm after each drain

Parameters:
K, 8, number of slots kept (K >= 1)
VAL_WIDTH, 32, distance value width
ID_WIDTH, 32, sample ID width
ID_STRIDE, 2, ID increment per accepted sample (interleaves with other channels)
TIE_KEEP_OLD, 1, 1: on equal values the earlier sample ranks first; 0: the later sample ranks first

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
clear  in  1  synchronous query abort/restart
id_base  in  ID_WIDTH  ID of the first sample of a query, sampled at re-arm
in_valid  in  1  input sample valid
in_ready  out  1  sorter can accept a sample
in_value  in  VAL_WIDTH  distance of the sample
in_last  in  1  final sample of the query
out_valid  out  1  result entry valid
out_ready  in  1  consumer accepts the entry
out_id  out  ID_WIDTH  sample ID of the entry
out_value  out  VAL_WIDTH  distance of the entry
out_last  out  1  final entry of the result
out_count  out  $clog2(K+1)  number of occupied slots

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Priority order: reset, then clear, then normal operation.
- Reset and clear actions (both identical):
  - state <= ACCEPT
  - all occupancy bits <= 0
  - rd_ptr <= 0
  - id_ctr <= id_base
- Output values at reset: in_ready=1, out_valid=0, out_id=0, out_value=0, out_last=0, out_count=0.
- States:
  - ACCEPT: in_ready=1.
  - DRAIN: in_ready=0; in_valid is ignored.
- Accept: occurs on in_valid & in_ready, with a single-cycle insert.
  - slot j "beats" when it is unoccupied, or when in_value < val[j] (TIE_KEEP_OLD=1) / in_value <= val[j] (TIE_KEEP_OLD=0).
  - Insert position p = the lowest slot that beats. Slots p..K-2 shift to p+1..K-1, and slot p gets {id_ctr, in_value} with occupancy 1.
  - If no slot beats, the sample is discarded. id_ctr still advances.
  - id_ctr <= id_ctr + ID_STRIDE, wrapping modulo 2^ID_WIDTH.
  - out_count increments, saturating at K.
- Transition on in_last: an accepted sample with in_last=1 is inserted in that same cycle. The state is DRAIN next cycle, with rd_ptr=0.
- DRAIN outputs:
  - out_valid = (rd_ptr < out_count).
  - out_id and out_value are slot[rd_ptr], gated to 0 when out_valid=0.
  - out_last = out_valid & (rd_ptr == out_count-1).
  - out_count is never 0 in DRAIN, because in_last always carries a sample.
- Drain handshake:
  - rd_ptr advances on out_valid & out_ready.
  - While out_ready=0, all outputs hold stable.
- Re-arm: the handshake of the out_last entry performs the reset/clear action. in_ready=1 on the next cycle.
- clear in any state, and reset mid-drain: remaining entries are lost and no out_last is produced.
- Latency: first out_valid occurs 1 cycle after the in_last handshake. Throughput is 1 sample/cycle in each direction.

Decomposition:
- Shared package knn_pkg:
  - state enum (ACCEPT, DRAIN)
  - slot struct typedef {occ, id, value}, parameterised by widths through localparams
- Sub-module knn_topk_cell: one slot.
  - Registers its slot and compares it with in_value under the tie policy.
  - Takes the beat flag from slot j-1 and chooses hold, shift-in, or load-new.
  - The top level instantiates K cells in a generate loop.
  - The top level holds the FSM, ID counter, occupancy count and drain mux.

Test Plan:
1. K=4, base=0, stride=2; values 50,10,30,20,40 (last on 40) -> drains (2,10),(6,20),(4,30),(8,40); out_last on the 4th entry; out_count=4.
2. K=4, base=5; values 7,3 (last) -> drains (7,3),(5,7); out_last on the 2nd entry; out_count=2.
3. Ties, base=0; values 9,9,9 (last) -> TIE_KEEP_OLD=1 drains ids 0,2,4; TIE_KEEP_OLD=0 drains ids 4,2,0.
4. Backpressure: out_ready low for 3 cycles after the 1st entry of scenario 1 -> (6,20) is held stable throughout; no entry is skipped or repeated.
5. All-ones value: single sample 0xFFFFFFFF (last) -> out_count=1; drains (0,0xFFFFFFFF) with out_last=1.
6. Abort and restart:
   - clear after 2 accepts -> next cycle in_ready=1 and out_count=0; the following sample has id=id_base.
   - reset mid-drain -> out_valid=0 next cycle.
   - back-to-back queries -> second query IDs restart at id_base.
